// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin sequencer sharing one sequential signed 32x32
// multiplier among N_REQ requesters, with a watchdog on the WAIT phase.
module mul_arbiter #(
  parameter int N_REQ       = 4,
  parameter int ID_W        = $clog2(N_REQ),
  parameter int TIMEOUT_CYC = 40
) (
  input  logic                 CLK_i,
  input  logic                 RSTN_i,
  input  logic [N_REQ-1:0]     REQ_i,
  input  logic [N_REQ*32-1:0]  DIN1_i,
  input  logic [N_REQ*32-1:0]  DIN2_i,
  output logic [N_REQ-1:0]     ACK_o,
  output logic [N_REQ-1:0]     RVALID_o,
  input  logic [N_REQ-1:0]     RREADY_i,
  output logic [63:0]          DOUT_o,
  output logic                 ERR_o,
  output logic [ID_W-1:0]      GNT_ID_o,
  output logic                 BUSY_o,
  output logic                 MUL_EN_o,
  output logic [31:0]          MUL_DIN1_o,
  output logic [31:0]          MUL_DIN2_o,
  input  logic                 MUL_BUSY_i,
  input  logic                 MUL_VALID_i,
  input  logic [63:0]          MUL_DOUT_i
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  localparam int              WD_W    = $clog2(TIMEOUT_CYC);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [ID_W:0]   N_REQ_W = (ID_W + 1)'(N_REQ);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);

  logic [1:0]       state;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  gnt_id;
  logic [31:0]      op1;
  logic [31:0]      op2;
  logic [WD_W-1:0]  wd;
  logic [63:0]      dout;
  logic             err;
  logic [N_REQ-1:0] ack;

  logic [ID_W-1:0]  pick;
  logic             pick_ok;
  logic [N_REQ-1:0] pick_oh;
  logic [ID_W:0]    cand_sum;
  logic [31:0]      cand_a;
  logic [31:0]      cand_b;

  // Winner search: first set REQ bit from rr_ptr upward with wrap, plus its operands.
  always_comb begin
    pick     = '0;
    pick_ok  = 1'b0;
    pick_oh  = '0;
    cand_sum = '0;
    cand_a   = '0;
    cand_b   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand_sum = {1'b0, rr_ptr} + (ID_W + 1)'(i);
      if (cand_sum >= N_REQ_W) begin
        cand_sum = cand_sum - N_REQ_W;
      end
      if (!pick_ok && REQ_i[cand_sum[ID_W-1:0]]) begin
        pick    = cand_sum[ID_W-1:0];
        pick_ok = 1'b1;
      end
    end
    if (pick_ok) begin
      pick_oh[pick] = 1'b1;
    end
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (pick == ID_W'(k)) begin
        cand_a = DIN1_i[32*k +: 32];
        cand_b = DIN2_i[32*k +: 32];
      end
    end
  end

  // Sequencer FSM: grant, launch multiplier, wait with watchdog, hold response.
  always_ff @(posedge CLK_i or negedge RSTN_i) begin
    if (!RSTN_i) begin
      state  <= S_IDLE;
      rr_ptr <= '0;
      gnt_id <= '0;
      op1    <= '0;
      op2    <= '0;
      wd     <= '0;
      dout   <= '0;
      err    <= 1'b0;
      ack    <= '0;
    end else begin
      ack <= '0;
      case (state)
        S_IDLE: begin
          if (pick_ok) begin
            op1    <= cand_a;
            op2    <= cand_b;
            gnt_id <= pick;
            ack    <= pick_oh;
            state  <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          wd    <= '0;
          err   <= 1'b0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          wd <= wd + 1'b1;
          // A valid result takes precedence over an expiring watchdog.
          if (MUL_VALID_i && !MUL_BUSY_i) begin
            dout  <= MUL_DOUT_i;
            err   <= 1'b0;
            state <= S_RESP;
          end else if (wd == WD_LAST) begin
            dout  <= '0;
            err   <= 1'b1;
            state <= S_RESP;
          end
        end
        S_RESP: begin
          if (RREADY_i[gnt_id]) begin
            rr_ptr <= (gnt_id == LAST_ID) ? '0 : gnt_id + 1'b1;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Response valid is decoded from the state so it drops the moment reset hits.
  always_comb begin
    RVALID_o = '0;
    if (state == S_RESP) begin
      RVALID_o[gnt_id] = 1'b1;
    end
  end

  assign ACK_o      = ack;
  assign DOUT_o     = dout;
  assign ERR_o      = err;
  assign GNT_ID_o   = gnt_id;
  assign BUSY_o     = (state != S_IDLE);
  assign MUL_EN_o   = (state == S_LAUNCH);
  assign MUL_DIN1_o = op1;
  assign MUL_DIN2_o = op2;

endmodule

// File: doc/mul_arbiter.md
Name: mul_arbiter

Overview:
- Round-robin arbiter/sequencer that shares one 32b x 32b sequential signed multiplier among N_REQ requesters.
- Per requester: accepts an operand pair, launches one multiplication, waits for the multiplier's VALID, then returns the 64b product to the granted requester with a ready/valid handshake.
- Sits between requester clients and the multiplier's EN/DIN/BUSY/VALID/DOUT interface, and includes a watchdog against a stuck multiplier.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, $clog2(N_REQ), width of the grant-ID field.
- TIMEOUT_CYC, 40, cycles allowed in WAIT before an error response; must be >= 34.

Ports:
- CLK_i  in  1  clock, single domain.
- RSTN_i  in  1  asynchronous active-low reset.
- REQ_i  in  N_REQ  per-requester request; held with operands until the matching ACK_o.
- DIN1_i  in  N_REQ*32  multiplicand per requester; slice k = [32k+31:32k].
- DIN2_i  in  N_REQ*32  multiplier operand per requester, same slicing.
- ACK_o  out  N_REQ  one-cycle pulse: operands of requester k captured.
- RVALID_o  out  N_REQ  result valid for requester k; held until RREADY_i[k].
- RREADY_i  in  N_REQ  requester k consumes result.
- DOUT_o  out  64  result, shared by all requesters; meaningful only while some RVALID_o bit is set.
- ERR_o  out  1  qualifies the current response as a timeout; DOUT_o = 0 in that case.
- GNT_ID_o  out  ID_W  index of the requester currently being served.
- BUSY_o  out  1  high whenever the FSM is not IDLE.
- MUL_EN_o  out  1  multiplier start.
- MUL_DIN1_o  out  32  multiplier operand 1.
- MUL_DIN2_o  out  32  multiplier operand 2.
- MUL_BUSY_i  in  1  multiplier busy.
- MUL_VALID_i  in  1  multiplier result valid; level, cleared by the next EN.
- MUL_DOUT_i  in  64  multiplier product.

Behaviour:
- Reset (async, RSTN_i low):
  - FSM = IDLE; rr pointer = 0.
  - All outputs 0: ACK_o, RVALID_o, ERR_o, MUL_EN_o, BUSY_o, GNT_ID_o, DOUT_o, MUL_DIN*_o.
  - Reset mid-operation abandons the job; no ACK or RVALID is produced for it.
- FSM: IDLE -> LAUNCH -> WAIT -> RESP -> IDLE.
- IDLE:
  - If any REQ_i is set, pick the first set bit searching from rr_ptr upward with wrap (rr_ptr itself has highest priority).
  - At the clock edge: latch the winner's DIN1/DIN2 into operand registers, load GNT_ID_o, pulse ACK_o[winner] for the next cycle, go to LAUNCH.
- LAUNCH (exactly 1 cycle):
  - MUL_EN_o = 1; MUL_DIN1_o/MUL_DIN2_o driven from the operand registers (stable from LAUNCH through WAIT).
  - Clear the watchdog; go to WAIT.
- WAIT:
  - MUL_EN_o = 0; the watchdog increments every cycle.
  - If MUL_VALID_i && !MUL_BUSY_i: capture MUL_DOUT_i into DOUT_o, ERR_o = 0, go to RESP.
  - Else if watchdog == TIMEOUT_CYC-1: DOUT_o = 0, ERR_o = 1, go to RESP.
  - Valid and timeout in the same cycle: valid wins.
- RESP:
  - RVALID_o[GNT_ID_o] = 1; DOUT_o and ERR_o held stable.
  - On RREADY_i[GNT_ID_o]: clear RVALID_o, set rr_ptr = (GNT_ID_o+1) mod N_REQ, go to IDLE.
  - RREADY_i bits of non-granted requesters are ignored.
- Latency with a compliant multiplier (33 cycles EN->VALID):
  - REQ seen in IDLE at cycle T -> ACK at T+1, MUL_EN at T+1, RVALID at T+35.
  - With RREADY already high, the next grant's ACK appears at T+37.
- Requests:
  - A REQ that arrives during a job waits; no new grant is issued until the FSM is back in IDLE.
  - A requester that keeps REQ high after its ACK is treated as a new job.
  - Requester k must hold its operands stable while REQ_i[k] is high.
- Arithmetic: the block is transparent. Products are signed two's complement as produced by the multiplier; no width change.
- Stale VALID: MUL_VALID_i is ignored in IDLE/LAUNCH. A VALID left high from the previous job is cleared by the EN edge and is never sampled as the new result.
- Only one of ACK_o/RVALID_o bits is ever set at a time; ACK_o and RVALID_o are never both nonzero.

Test Plan:
- Single job: REQ[2] with DIN1=7, DIN2=-3 (0xFFFFFFFD) at T -> ACK_o=0b0100 at T+1, MUL_EN pulse at T+1, RVALID_o[2] at T+35, DOUT_o=0xFFFFFFFF_FFFFFFEB, ERR_o=0, GNT_ID_o=2.
- Round-robin: REQ=0b1111 held, RREADY=all 1, each requester's operands = (k+1, 0x10) -> ACK order 0,1,2,3,0, products 0x10, 0x20, 0x30, 0x40; no requester served twice before all others.
- Backpressure: hold RREADY_i[1]=0 for 20 cycles after RVALID_o[1] -> DOUT_o stable, no new ACK while REQ[0] is pending; release -> IDLE, then ACK_o[0] two cycles later.
- Extremes: 0x80000000 x 0x80000000 -> 0x40000000_00000000; 0xFFFFFFFF x 1 -> 0xFFFFFFFF_FFFFFFFF; 0x7FFFFFFF x 0x7FFFFFFF -> 0x3FFFFFFF_00000001.
- Timeout: stub multiplier never asserts VALID -> RVALID at LAUNCH+1+TIMEOUT_CYC, ERR_o=1, DOUT_o=0; the next job completes with ERR_o=0.
- Reset mid-WAIT: drop RSTN_i 10 cycles after ACK -> all outputs 0 immediately, no RVALID; after release REQ[3] gets ACK with rr_ptr=0 ordering.
